// File: rtl/sev_seg_scan_ctrl.sv
// Multiplexed common-anode 7-segment driver with a sequential double-dabble BCD converter.
// Optional leading-zero blanking is enabled by defining SEVSEG_LZ_BLANK_EN.
module sev_seg_scan_ctrl #(
    parameter int NUM_DIGITS = 4,
    parameter int DATA_W     = 16,
    parameter int CLK_DIV    = 50000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic                  mode,
    input  logic [DATA_W-1:0]     data_in,
    input  logic [NUM_DIGITS-1:0] dp_in,
    output logic                  busy,
    output logic                  ovf,
    output logic [7:0]            cathodes,
    output logic [NUM_DIGITS-1:0] anodes
);

    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PRE_W = $clog2(CLK_DIV);
    localparam int CNT_W = $clog2(DATA_W + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_CONV   = 2'd1;
    localparam logic [1:0] S_COMMIT = 2'd2;

    logic [1:0]            state;
    logic [DATA_W-1:0]     data_q;
    logic                  mode_q;
    logic [NUM_DIGITS-1:0] dp_q;
    logic [BCD_W-1:0]      bcd_q;
    logic                  bcd_ovf_q;
    logic [CNT_W-1:0]      bit_cnt;

    logic [BCD_W-1:0]      disp_digits;
    logic [NUM_DIGITS-1:0] disp_dp;
    logic                  disp_ovf;
    logic                  disp_valid;

    logic [PRE_W-1:0]      pre_cnt;
    logic [IDX_W-1:0]      digit_idx;

    logic [BCD_W-1:0]      bcd_adj;
    logic [BCD_W-1:0]      hex_digits;
    logic                  hex_ovf;
    logic [NUM_DIGITS-1:0] blank_mask;
    logic [3:0]            cur_nib;
    logic [6:0]            cur_seg;

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] lit;
        lit = 7'h00;
        case (nib)
            4'h0: lit = 7'h3F;
            4'h1: lit = 7'h06;
            4'h2: lit = 7'h5B;
            4'h3: lit = 7'h4F;
            4'h4: lit = 7'h66;
            4'h5: lit = 7'h6D;
            4'h6: lit = 7'h7D;
            4'h7: lit = 7'h07;
            4'h8: lit = 7'h7F;
            4'h9: lit = 7'h6F;
            4'hA: lit = 7'h77;
            4'hB: lit = 7'h7C;
            4'hC: lit = 7'h39;
            4'hD: lit = 7'h5E;
            4'hE: lit = 7'h79;
            4'hF: lit = 7'h71;
        endcase
        return ~lit;
    endfunction

    // NOTE: every combinational output gets a default before any conditional update so no latch is inferred.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
    end

    generate
        if (DATA_W > BCD_W) begin : g_hex_wide
            assign hex_digits = data_q[BCD_W-1:0];
            assign hex_ovf    = |data_q[DATA_W-1:BCD_W];
        end else if (DATA_W == BCD_W) begin : g_hex_exact
            assign hex_digits = data_q;
            assign hex_ovf    = 1'b0;
        end else begin : g_hex_narrow
            assign hex_digits = {{(BCD_W-DATA_W){1'b0}}, data_q};
            assign hex_ovf    = 1'b0;
        end
    endgenerate

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            data_q      <= '0;
            mode_q      <= 1'b0;
            dp_q        <= '0;
            bcd_q       <= '0;
            bcd_ovf_q   <= 1'b0;
            bit_cnt     <= '0;
            // NOTE: the display register is explicitly reset; disp_valid keeps it blank until a commit.
            disp_digits <= '0;
            disp_dp     <= '0;
            disp_ovf    <= 1'b0;
            disp_valid  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (load) begin
                        data_q    <= data_in;
                        mode_q    <= mode;
                        dp_q      <= dp_in;
                        bcd_q     <= '0;
                        bcd_ovf_q <= 1'b0;
                        bit_cnt   <= '0;
                        state     <= mode ? S_CONV : S_COMMIT;
                    end
                end
                S_CONV: begin
                    // Carry out of the top nibble means the value needs more digits than we have.
                    bcd_q     <= {bcd_adj[BCD_W-2:0], data_q[DATA_W-1]};
                    bcd_ovf_q <= bcd_ovf_q | bcd_adj[BCD_W-1];
                    data_q    <= {data_q[DATA_W-2:0], 1'b0};
                    bit_cnt   <= bit_cnt + CNT_W'(1);
                    if (bit_cnt == CNT_W'(DATA_W - 1)) state <= S_COMMIT;
                end
                S_COMMIT: begin
                    disp_digits <= mode_q ? bcd_q : hex_digits;
                    disp_dp     <= dp_q;
                    disp_ovf    <= mode_q ? bcd_ovf_q : hex_ovf;
                    disp_valid  <= 1'b1;
                    state       <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy = (state == S_CONV);
    assign ovf  = disp_ovf;

`ifdef SEVSEG_LZ_BLANK_EN
    always_comb begin
        logic zero_above;
        zero_above = 1'b1;
        blank_mask = '0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_above    = zero_above & (disp_digits[4*i +: 4] == 4'd0);
            blank_mask[i] = zero_above & ~disp_ovf;
        end
    end
`else
    assign blank_mask = '0;
`endif

    assign cur_nib = disp_digits[{digit_idx, 2'b00} +: 4];

    always_comb begin
        if (disp_ovf)                   cur_seg = 7'b0111111;
        else if (blank_mask[digit_idx]) cur_seg = 7'h7F;
        else                            cur_seg = seg_decode(cur_nib);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt   <= '0;
            digit_idx <= '0;
            anodes    <= '1;
            cathodes  <= 8'hFF;
        end else begin
            if (pre_cnt == PRE_W'(CLK_DIV - 1)) begin
                pre_cnt   <= '0;
                digit_idx <= (digit_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : digit_idx + IDX_W'(1);
            end else begin
                pre_cnt <= pre_cnt + PRE_W'(1);
            end
            anodes   <= ~(NUM_DIGITS'(1) << digit_idx);
            cathodes <= disp_valid ? {~disp_dp[digit_idx], cur_seg} : 8'hFF;
        end
    end

endmodule

// File: tb/tb_sev_seg_scan_ctrl.sv
// Self-checking bench for sev_seg_scan_ctrl: behavioural display model plus literal spot checks.
module tb_sev_seg_scan_ctrl;

    localparam int ND = 4;
    localparam int DW = 16;
    localparam int CD = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          load = 1'b0;
    logic          mode = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic [ND-1:0] dp_in = '0;
    logic          busy;
    logic          ovf;
    logic [7:0]    cathodes;
    logic [ND-1:0] anodes;

    sev_seg_scan_ctrl #(.NUM_DIGITS(ND), .DATA_W(DW), .CLK_DIV(CD)) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .mode(mode), .data_in(data_in),
        .dp_in(dp_in), .busy(busy), .ovf(ovf), .cathodes(cathodes), .anodes(anodes)
    );

    always #5 clk = ~clk;

    // Active-low glyphs 0..F with the DP off.
    localparam logic [7:0] SEG_AL [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                           8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    int checks = 0;
    int failures = 0;
    int busy_seen = 0;
    logic [7:0] cap [ND];

    int         edge_k, load_edge, commit_edge;
    bit         pend, pend_mode;
    int         n_dig [ND];
    logic [3:0] n_dp;
    bit         n_ovf;
    int         d_dig [ND];
    logic [3:0] d_dp;
    bit         d_ovf, d_valid;
    logic [3:0] e_an;
    logic [7:0] e_cath;
    bit         e_busy, e_ovf;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_blank(input int i);
        bit b;
        b = 1'b0;
`ifdef SEVSEG_LZ_BLANK_EN
        if (i >= 1) begin
            b = 1'b1;
            for (int j = i; j < ND; j++) if (d_dig[j] != 0) b = 1'b0;
        end
`endif
        return b;
    endfunction

    function automatic logic [7:0] model_cath(input int i);
        logic [6:0] seg;
        logic [7:0] g;
        if (!d_valid) return 8'hFF;
        g = SEG_AL[d_dig[i]];
        if (d_ovf)               seg = 7'b0111111;
        else if (model_blank(i)) seg = 7'h7F;
        else                     seg = g[6:0];
        return {~d_dp[i], seg};
    endfunction

    task automatic model_reset();
        edge_k = 0; pend = 1'b0; pend_mode = 1'b0; load_edge = 0; commit_edge = 0;
        d_valid = 1'b0; d_ovf = 1'b0; d_dp = '0;
        for (int i = 0; i < ND; i++) d_dig[i] = 0;
        e_an = 4'hF; e_cath = 8'hFF; e_busy = 1'b0; e_ovf = 1'b0;
    endtask

    // One rising edge of the reference: scan output, then commit, then accept a new load.
    task automatic model_step(input bit ld, input bit md, input int v, input logic [3:0] dp);
        int idx, p10;
        bit was_pend;
        idx    = (edge_k / CD) % ND;
        e_an   = ~(4'b0001 << idx);
        e_cath = model_cath(idx);
        was_pend = pend;
        if (pend && edge_k == commit_edge) begin
            for (int i = 0; i < ND; i++) d_dig[i] = n_dig[i];
            d_dp = n_dp; d_ovf = n_ovf; d_valid = 1'b1; pend = 1'b0;
        end
        if (!was_pend && ld) begin
            pend = 1'b1; pend_mode = md; load_edge = edge_k;
            commit_edge = edge_k + (md ? DW + 1 : 1);
            n_dp = dp;
            if (md) begin
                n_ovf = (v >= 10000);
                p10 = 1;
                for (int i = 0; i < ND; i++) begin
                    n_dig[i] = (v / p10) % 10;
                    p10 = p10 * 10;
                end
            end else begin
                n_ovf = ((v >> (4 * ND)) != 0);
                for (int i = 0; i < ND; i++) n_dig[i] = (v >> (4 * i)) & 15;
            end
        end
        e_busy = pend && pend_mode && (edge_k < load_edge + DW);
        e_ovf  = d_ovf;
        edge_k++;
    endtask

    task automatic cycle(input bit ld, input bit md, input int v, input logic [3:0] dp);
        load = ld; mode = md; data_in = v[DW-1:0]; dp_in = dp;
        @(posedge clk);
        model_step(ld, md, v, dp);
        @(negedge clk);
        check("anodes", anodes, e_an);
        check("cathodes", cathodes, e_cath);
        check("busy", busy, e_busy);
        check("ovf", ovf, e_ovf);
        if (busy === 1'b1) busy_seen++;
        case (anodes)
            4'hE: cap[0] = cathodes;
            4'hD: cap[1] = cathodes;
            4'hB: cap[2] = cathodes;
            4'h7: cap[3] = cathodes;
            default: ;
        endcase
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 0, 4'h0);
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        repeat (n) @(posedge clk);
        @(negedge clk);
        check("rst_cathodes", cathodes, 8'hFF);
        check("rst_anodes", anodes, 4'hF);
        check("rst_busy", busy, 1'b0);
        check("rst_ovf", ovf, 1'b0);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic check_caps(input string tag, input logic [7:0] c3, input logic [7:0] c2,
                              input logic [7:0] c1, input logic [7:0] c0);
        check({tag, "_d3"}, cap[3], c3);
        check({tag, "_d2"}, cap[2], c2);
        check({tag, "_d1"}, cap[1], c1);
        check({tag, "_d0"}, cap[0], c0);
    endtask

    initial begin
        logic [3:0] walk [4];
        int sel, v;
        walk = '{4'hE, 4'hD, 4'hB, 4'h7};
        for (int i = 0; i < ND; i++) cap[i] = 8'h00;
        model_reset();
        @(negedge clk);
        do_reset(3);

        for (int i = 1; i <= 17; i++) begin
            idle(1);
            if ((i - 1) % 4 == 0) check("walk", anodes, walk[((i - 1) / 4) % 4]);
        end

        busy_seen = 0;
        cycle(1'b1, 1'b1, 1234, 4'h0);
        idle(20);
        check("busy_len_1234", busy_seen, 16);
        idle(2 * ND * CD);
        check_caps("dec1234", 8'hF9, 8'hA4, 8'hB0, 8'h99);

        cycle(1'b1, 1'b0, 16'hBEEF, 4'h0);
        idle(2 + 2 * ND * CD);
        check_caps("hexBEEF", 8'h83, 8'h86, 8'h86, 8'h8E);
        check("hexBEEF_ovf", ovf, 1'b0);

        cycle(1'b1, 1'b1, 12345, 4'h0);
        idle(4);
        cycle(1'b1, 1'b1, 1, 4'h0);
        idle(16 + 2 * ND * CD);
        check_caps("ovf12345", 8'hBF, 8'hBF, 8'hBF, 8'hBF);
        check("ovf12345_flag", ovf, 1'b1);

        cycle(1'b1, 1'b1, 7, 4'b0010);
        idle(20 + 2 * ND * CD);
`ifdef SEVSEG_LZ_BLANK_EN
        check_caps("dp7", 8'hFF, 8'hFF, 8'h7F, 8'hF8);
`else
        check_caps("dp7", 8'hC0, 8'hC0, 8'h40, 8'hF8);
`endif

        cycle(1'b1, 1'b1, 5678, 4'h0);
        idle(8);
        #2 rst_n = 1'b0;
        #1;
        check("abort_cathodes", cathodes, 8'hFF);
        check("abort_anodes", anodes, 4'hF);
        check("abort_busy", busy, 1'b0);
        check("abort_ovf", ovf, 1'b0);
        do_reset(2);
        idle(5);
        cycle(1'b1, 1'b1, 4321, 4'h0);
        idle(20 + 2 * ND * CD);
        check_caps("dec4321", 8'h99, 8'hB0, 8'hA4, 8'hF9);

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 5) == 0) begin
                sel = $urandom_range(0, 5);
                case (sel)
                    0: v = $urandom_range(0, 9999);
                    1: v = 9999;
                    2: v = 10000;
                    3: v = $urandom_range(0, 65535);
                    4: v = 0;
                    default: v = $urandom_range(0, 99);
                endcase
                cycle(1'b1, 1'($urandom_range(0, 1)), v, 4'($urandom_range(0, 15)));
            end else begin
                idle(1);
            end
        end
        idle(40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
